teclado_ps2: RTL and testbench
==============================

# teclado_ps2

PS/2 keyboard receiver and key-state decoder that produces the `keysout[3:0]` held-key vector consumed by the ship controller and the rest of the game logic. It deserialises device-to-host PS/2 frames, checks their framing and parity, and decodes make/break scancodes into per-key held levels. It sits between the board's PS/2 pins and every block that reads `keysout`.

## Interface
- `FILTRO`, 8: number of consecutive identical synchronised `PS2_CLK` samples required before the filtered clock changes level.
- `TIMEOUT_CICLOS`, 50000: maximum idle cycles between falling edges inside a frame (1 ms at 50 MHz).
- `CLOCK_50` in 1: system clock, 50 MHz. Sole clock.
- `reset` in 1: asynchronous, active-low reset.
- `PS2_CLK` in 1: raw PS/2 clock, asynchronous to `CLOCK_50`.
- `PS2_DAT` in 1: raw PS/2 data, asynchronous to `CLOCK_50`.
- `keysout` out 4: held-key levels. [0] right, [1] fire, [2] left, [3] restart.
- `codigo` out 8: last accepted byte.
- `codigo_valido` out 1: one-cycle strobe when `codigo` updates.
- `erro_quadro` out 1: one-cycle strobe on a parity, stop-bit or timeout error.

## Operation
- Input conditioning: `PS2_CLK` and `PS2_DAT` each pass through a 2-flop synchroniser. The filtered clock `clk_f` resets to 1 and takes the synchronised level only after `FILTRO` consecutive equal samples. `queda` is a one-cycle pulse on each `clk_f` 1→0 transition.
- Frame FSM. Every bit is sampled from the synchronised `PS2_DAT` in a `queda` cycle.
  - IDLE: on `queda` with data 0 → DADOS. A start bit of 1 is ignored and the FSM stays in IDLE.
  - DADOS: shift 8 bits in, LSB first. After the 8th bit → PARIDADE.
  - PARIDADE: capture the parity bit → PARADA.
  - PARADA: the stop bit must be 1 and the XOR of the 8 data bits and the parity bit must be 1 (odd parity). If both hold, accept the byte. Otherwise pulse `erro_quadro`. Either way → IDLE.
  - Any state other than IDLE: a counter clears on every `queda`. When it reaches `TIMEOUT_CICLOS` the FSM goes to IDLE, pulses `erro_quadro` and discards any partial byte.
- Decoder, run on each accepted byte:
  - 0xE0 sets `pend_e0`. 0xF0 sets `pend_f0`. Neither produces a key update.
  - Any other byte is a key code. It sets the mapped bit (make) if `pend_f0` is 0 and clears it (break) if `pend_f0` is 1. Both pending flags then clear.
  - Non-extended mapping: 0x23 (D) → [0], 0x29 (space) → [1], 0x1C (A) → [2], 0x5A (Enter) → [3]. Any other code changes nothing.
  - With `pend_e0` set, mapping depends on the macro (see Configuration).
  - Typematic repeats of a make code leave an already-set bit set, with no glitch.
  - `erro_quadro` also clears `pend_e0` and `pend_f0`. `keysout` is unchanged by an error.
- `codigo_valido` pulses for every accepted byte, including the prefix bytes 0xE0 and 0xF0.

## Timing
- Reset values: `keysout`=0, `codigo`=0x00, `codigo_valido`=0, `erro_quadro`=0, FSM in IDLE, `clk_f`=1, pending flags 0, timeout counter 0.
- Edge latency: a raw `PS2_CLK` fall reaches `queda` after 2 synchroniser cycles, then `FILTRO` filter cycles, then 1 cycle.
- Accept latency: on the clock edge after the stop-bit `queda` cycle, the following update together:
  - `codigo` and `codigo_valido`;
  - `keysout`, when the byte is a mapped key code.
- `erro_quadro` asserts on the same edge an accepted byte would have.
- `keysout` is registered and never changes except on that edge or on reset.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). A later partial frame on the line is discarded by the start-bit check or by the timeout.
- Pulses narrower than `FILTRO` cycles on `PS2_CLK` produce no `queda`.

## Configuration
- `TECLADO_SETAS_EN` defined: extended codes also map. E0 74 (right arrow) → [0], E0 6B (left arrow) → [2], E0 5A (keypad Enter) → [3]. Other extended codes change nothing.
- `TECLADO_SETAS_EN` undefined: every E0-prefixed key code, make or break, is ignored for `keysout`. `codigo` and `codigo_valido` still report it.

## Test plan
- Reset, then send the frame for 0x23 with correct parity → one `codigo_valido` pulse, `codigo`=0x23, `keysout`=4'b0001.
- Send F0 then 23 → two `codigo_valido` pulses, `keysout` back to 4'b0000.
- Send 0x29 with the parity bit inverted → `erro_quadro` pulses once, no `codigo_valido`, `keysout` unchanged.
- Stop `PS2_CLK` after 4 data bits for more than `TIMEOUT_CICLOS` cycles → `erro_quadro` pulses and the FSM is in IDLE. A following full frame for 0x1C is received correctly and sets `keysout`[2].
- Send E0 74:
  - with `TECLADO_SETAS_EN` → `keysout`[0]=1; E0 F0 74 then clears it.
  - without the macro → `keysout` stays 0 while `codigo` reads 0x74.
- Inject 3-cycle glitches on `PS2_CLK` with `FILTRO`=8 between valid frames → no extra bits, and every frame decodes correctly.

Source files
------------

// File: rtl/teclado_ps2_if.sv
// rtl/teclado_ps2_if.sv - PS/2 pin and decoded key bundle for teclado_ps2
interface teclado_ps2_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [3:0] keysout;
  logic [7:0] codigo;
  logic       codigo_valido;
  logic       erro_quadro;

  // master: board/bench side driving the PS/2 lines and reading keys
  modport master (
    output PS2_CLK, PS2_DAT,
    input  keysout, codigo, codigo_valido, erro_quadro
  );

  // slave: the receiver itself
  modport slave (
    input  PS2_CLK, PS2_DAT,
    output keysout, codigo, codigo_valido, erro_quadro
  );
endinterface

// File: rtl/teclado_ps2.sv
// rtl/teclado_ps2.sv - PS/2 keyboard receiver and key-state decoder (option: TECLADO_SETAS_EN maps E0 arrow/keypad-enter codes)
module teclado_ps2 #(
  parameter int FILTRO         = 8,
  parameter int TIMEOUT_CICLOS = 50000
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  teclado_ps2_if.slave   bus
);

  localparam int FILT_W = $clog2(FILTRO + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTRO - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT_CICLOS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DADOS    = 2'd1,
    PARIDADE = 2'd2,
    PARADA   = 2'd3
  } estado_t;

  // synchronisers reset to the idle line level so no edge is seen after reset
  logic ps2c_s1_q, ps2c_s2_q, ps2d_s1_q, ps2d_s2_q;

  logic              clk_f_q, clk_f_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic              queda_q, queda_d;

  estado_t           state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              par_q, par_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic [7:0]        codigo_q, codigo_d;
  logic              valido_q, valido_d;
  logic              erro_q, erro_d;
  logic [3:0]        keys_q, keys_d;
  logic              pend_e0_q, pend_e0_d;
  logic              pend_f0_q, pend_f0_d;

  logic              accept, frame_err;
  logic              hit;
  logic [1:0]        idx;

  // two-flop synchronisers for both raw PS/2 pins
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      ps2c_s1_q <= 1'b1;
      ps2c_s2_q <= 1'b1;
      ps2d_s1_q <= 1'b1;
      ps2d_s2_q <= 1'b1;
    end else begin
      ps2c_s1_q <= bus.PS2_CLK;
      ps2c_s2_q <= ps2c_s1_q;
      ps2d_s1_q <= bus.PS2_DAT;
      ps2d_s2_q <= ps2d_s1_q;
    end
  end

  // glitch filter: the filtered clock follows only after FILTRO differing samples in a row
  always_comb begin
    clk_f_d    = clk_f_q;
    filt_cnt_d = '0;
    if (ps2c_s2_q != clk_f_q) begin
      if (filt_cnt_q == FILT_MAX) begin
        clk_f_d = ps2c_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FILT_W'(1);
      end
    end
    queda_d = clk_f_q & ~clk_f_d;
  end

  // filter and falling-edge pulse registers
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      clk_f_q    <= 1'b1;
      filt_cnt_q <= '0;
      queda_q    <= 1'b0;
    end else begin
      clk_f_q    <= clk_f_d;
      filt_cnt_q <= filt_cnt_d;
      queda_q    <= queda_d;
    end
  end

  // frame FSM, inactivity timeout and make/break decoder
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    codigo_d  = codigo_q;
    valido_d  = 1'b0;
    erro_d    = 1'b0;
    keys_d    = keys_q;
    pend_e0_d = pend_e0_q;
    pend_f0_d = pend_f0_q;
    accept    = 1'b0;
    frame_err = 1'b0;
    hit       = 1'b0;
    idx       = 2'd0;

    if (state_q == IDLE || queda_q) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (queda_q && !ps2d_s2_q) begin
          state_d   = DADOS;
          bit_cnt_d = 3'd0;
        end
      end
      DADOS: begin
        if (queda_q) begin
          shift_d   = {ps2d_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARIDADE;
          end
        end
      end
      PARIDADE: begin
        if (queda_q) begin
          par_d   = ps2d_s2_q;
          state_d = PARADA;
        end
      end
      PARADA: begin
        if (queda_q) begin
          if (ps2d_s2_q && ((^shift_q) ^ par_q)) begin
            accept = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // a stalled line abandons the frame; the partial byte is never reported
    if (state_q != IDLE && !queda_q && tmo_q == TMO_MAX) begin
      state_d   = IDLE;
      frame_err = 1'b1;
      tmo_d     = '0;
    end

    if (!pend_e0_q) begin
      case (shift_q)
        8'h23: begin hit = 1'b1; idx = 2'd0; end
        8'h29: begin hit = 1'b1; idx = 2'd1; end
        8'h1C: begin hit = 1'b1; idx = 2'd2; end
        8'h5A: begin hit = 1'b1; idx = 2'd3; end
        default: ;
      endcase
    end
`ifdef TECLADO_SETAS_EN
    else begin
      case (shift_q)
        8'h74: begin hit = 1'b1; idx = 2'd0; end
        8'h6B: begin hit = 1'b1; idx = 2'd2; end
        8'h5A: begin hit = 1'b1; idx = 2'd3; end
        default: ;
      endcase
    end
`endif

    if (frame_err) begin
      erro_d    = 1'b1;
      pend_e0_d = 1'b0;
      pend_f0_d = 1'b0;
    end

    if (accept) begin
      codigo_d = shift_q;
      valido_d = 1'b1;
      if (shift_q == 8'hE0) begin
        pend_e0_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        pend_f0_d = 1'b1;
      end else begin
        // writing the same level on a typematic repeat keeps the bit steady
        if (hit) begin
          keys_d[idx] = ~pend_f0_q;
        end
        pend_e0_d = 1'b0;
        pend_f0_d = 1'b0;
      end
    end
  end

  // frame, decoder and output registers
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      codigo_q  <= 8'h00;
      valido_q  <= 1'b0;
      erro_q    <= 1'b0;
      keys_q    <= 4'b0000;
      pend_e0_q <= 1'b0;
      pend_f0_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      codigo_q  <= codigo_d;
      valido_q  <= valido_d;
      erro_q    <= erro_d;
      keys_q    <= keys_d;
      pend_e0_q <= pend_e0_d;
      pend_f0_q <= pend_f0_d;
    end
  end

  assign bus.keysout       = keys_q;
  assign bus.codigo        = codigo_q;
  assign bus.codigo_valido = valido_q;
  assign bus.erro_quadro   = erro_q;

endmodule

// File: tb/tb_teclado_ps2.sv
// tb/tb_teclado_ps2.sv - scoreboard bench for teclado_ps2 with a key-table reference model
module tb_teclado_ps2;
  localparam int FILTRO = 8;
  localparam int TMO    = 2000;
  localparam int HALF   = 30;
`ifdef TECLADO_SETAS_EN
  localparam bit SETAS = 1'b1;
`else
  localparam bit SETAS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  teclado_ps2_if bus();

  teclado_ps2 #(.FILTRO(FILTRO), .TIMEOUT_CICLOS(TMO)) dut (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (bus.slave)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    logic [3:0] keys;
  } exp_t;

  exp_t       expq[$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] m_keys = 4'b0;
  bit         m_e0 = 1'b0;
  bit         m_f0 = 1'b0;
  int         plain_map[int];
  int         ext_map[int];
  logic [3:0] prev_keys = 4'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // reference: key table lookup with make/break prefix state
  function automatic void model_byte(input logic [7:0] b);
    exp_t e;
    if (b == 8'hE0) m_e0 = 1'b1;
    else if (b == 8'hF0) m_f0 = 1'b1;
    else begin
      if (!m_e0 && plain_map.exists(int'(b))) m_keys[plain_map[int'(b)]] = !m_f0;
      else if (m_e0 && ext_map.exists(int'(b))) m_keys[ext_map[int'(b)]] = !m_f0;
      m_e0 = 1'b0;
      m_f0 = 1'b0;
    end
    e.is_err = 1'b0; e.code = b; e.keys = m_keys;
    expq.push_back(e);
  endfunction

  function automatic void model_err();
    exp_t e;
    m_e0 = 1'b0;
    m_f0 = 1'b0;
    e.is_err = 1'b1; e.code = 8'h00; e.keys = m_keys;
    expq.push_back(e);
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      bus.PS2_DAT = f[i];
      cyc(HALF);
      bus.PS2_CLK = 1'b0;
      cyc(HALF);
      bus.PS2_CLK = 1'b1;
    end
    bus.PS2_DAT = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    logic       par;
    logic [10:0] f;
    par = ~(^b) ^ bad_par;
    f = {1'b1, par, b, 1'b0};
    if (bad_par) model_err();
    else model_byte(b);
    send_bits(f, 11);
    cyc(2 * HALF);
  endtask

  task automatic glitch();
    bus.PS2_CLK = 1'b0;
    cyc(3);
    bus.PS2_CLK = 1'b1;
    cyc(15);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 5000) begin
      cyc(1);
      n++;
    end
    chk(name, expq.size(), 0);
  endtask

  // monitor: every DUT strobe pops one expectation; keys may move only on a strobe
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_keys = 4'b0;
    end else if (bus.codigo_valido || bus.erro_quadro) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe valido=%0b erro=%0b codigo=%0h", bus.codigo_valido, bus.erro_quadro, bus.codigo);
      end else begin
        e = expq.pop_front();
        chk("strobe_kind_erro", bus.erro_quadro, e.is_err);
        chk("strobe_kind_valido", bus.codigo_valido, !e.is_err);
        if (!e.is_err) chk("codigo", bus.codigo, e.code);
        chk("keysout", bus.keysout, e.keys);
      end
      prev_keys = bus.keysout;
    end else if (bus.keysout !== prev_keys) begin
      total++;
      bad++;
      $display("FAIL keys_without_strobe actual=%0h required=%0h", bus.keysout, prev_keys);
      prev_keys = bus.keysout;
    end
  end

  initial begin
    logic [7:0] pool [0:9];
    logic [7:0] b;
    plain_map[32'h23] = 0; plain_map[32'h29] = 1; plain_map[32'h1C] = 2; plain_map[32'h5A] = 3;
    if (SETAS) begin
      ext_map[32'h74] = 0; ext_map[32'h6B] = 2; ext_map[32'h5A] = 3;
    end
    pool[0] = 8'h23; pool[1] = 8'h29; pool[2] = 8'h1C; pool[3] = 8'h5A; pool[4] = 8'hE0;
    pool[5] = 8'hF0; pool[6] = 8'h74; pool[7] = 8'h6B; pool[8] = 8'h00; pool[9] = 8'h00;

    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    cyc(3);
    #1;
    chk("rst_keysout", bus.keysout, 4'h0);
    chk("rst_codigo", bus.codigo, 8'h00);
    chk("rst_valido", bus.codigo_valido, 1'b0);
    chk("rst_erro", bus.erro_quadro, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    cyc(5);

    send_byte(8'h23, 1'b0);
    drain("drain_make_d");
    chk("make_d_keys", bus.keysout, 4'b0001);
    chk("make_d_codigo", bus.codigo, 8'h23);

    send_byte(8'hF0, 1'b0);
    send_byte(8'h23, 1'b0);
    drain("drain_break_d");
    chk("break_d_keys", bus.keysout, 4'b0000);

    send_byte(8'h29, 1'b1);
    drain("drain_parity");
    chk("parity_keys", bus.keysout, 4'b0000);
    chk("parity_codigo_kept", bus.codigo, 8'h23);

    // start bit plus 4 data bits, then the line goes quiet
    model_err();
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
    cyc(TMO + 500);
    drain("drain_timeout");
    send_byte(8'h1C, 1'b0);
    drain("drain_after_timeout");
    chk("after_timeout_keys", bus.keysout, 4'b0100);

    send_byte(8'hE0, 1'b0);
    send_byte(8'h74, 1'b0);
    drain("drain_e0_74");
    chk("e0_74_codigo", bus.codigo, 8'h74);
    chk("e0_74_keys", bus.keysout, SETAS ? 4'b0101 : 4'b0100);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h74, 1'b0);
    drain("drain_e0_f0_74");
    chk("e0_f0_74_keys", bus.keysout, 4'b0100);

    glitch();
    send_byte(8'h5A, 1'b0);
    glitch();
    glitch();
    send_byte(8'h5A, 1'b0);
    glitch();
    send_byte(8'hF0, 1'b0);
    glitch();
    send_byte(8'h5A, 1'b0);
    glitch();
    send_byte(8'h29, 1'b0);
    drain("drain_glitch");
    chk("glitch_keys", bus.keysout, 4'b0110);

    for (int i = 0; i < 25; i++) begin
      b = pool[$urandom_range(0, 9)];
      if (b == 8'h00) b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) glitch();
      send_byte(b, $urandom_range(0, 7) == 0);
    end
    drain("drain_random");

    // reset in the middle of a frame
    send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 5);
    @(negedge clk) rst_n = 1'b0;
    m_keys = 4'b0; m_e0 = 1'b0; m_f0 = 1'b0;
    cyc(2);
    #1;
    chk("midrst_keys", bus.keysout, 4'h0);
    chk("midrst_codigo", bus.codigo, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    cyc(10);
    send_byte(8'h23, 1'b0);
    drain("drain_after_reset");
    chk("after_reset_keys", bus.keysout, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
